pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_renderer_pkg.sv | 76 +++++++
 rtl/pong_renderer_digit_glyph_rom.sv | 21 ++
 rtl/pong_renderer.sv | 158 +++++++++++++++
 tb/tb_pong_renderer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_renderer_pkg.sv
// Shared constants, payload types and glyph patterns for the Pong VGA renderer.
package pong_renderer_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned CNT_W        = 10;

    localparam logic [7:0] COL_BALL    = 8'hFF;
    localparam logic [7:0] COL_PLAYER  = 8'h1C;
    localparam logic [7:0] COL_COM     = 8'hE0;
    localparam logic [7:0] COL_SCORE   = 8'hFF;
    localparam logic [7:0] COL_NET     = 8'h92;
    localparam logic [7:0] COL_BG      = 8'h00;
    localparam logic [7:0] COL_BG_OVER = 8'h02;
    localparam logic [7:0] COL_BLANK   = 8'h00;

    localparam int unsigned GEO_W           = 160;
    localparam int unsigned GEO_H           = 120;
    localparam int unsigned NET_X           = 79;
    localparam int unsigned P_DIGIT_X       = 64;
    localparam int unsigned C_DIGIT_X       = 90;
    localparam int unsigned DIGIT_Y         = 4;
    localparam int unsigned GLYPH_COLS      = 3;
    localparam int unsigned GLYPH_ROWS      = 5;
    localparam int unsigned GLYPH_CELL_LOG2 = 1;
    localparam int unsigned DIGIT_W         = GLYPH_COLS << GLYPH_CELL_LOG2;
    localparam int unsigned DIGIT_H         = GLYPH_ROWS << GLYPH_CELL_LOG2;
    localparam int unsigned GAME_OVER_SCORE = 9;

    typedef struct packed {
        logic [7:0] ball_x;
        logic [6:0] ball_y;
        logic [7:0] player_x;
        logic [6:0] player_y;
        logic [7:0] com_x;
        logic [6:0] com_y;
        logic [3:0] player_score;
        logic [3:0] com_score;
    } shadow_t;

    // Rows top to bottom, leftmost column in the MSB of each 3-bit row.
    function automatic logic [14:0] glyph_bits(input logic [3:0] digit);
        case (digit)
            4'd0:    glyph_bits = 15'b111_101_101_101_111;
            4'd1:    glyph_bits = 15'b010_110_010_010_111;
            4'd2:    glyph_bits = 15'b111_001_111_100_111;
            4'd3:    glyph_bits = 15'b111_001_111_001_111;
            4'd4:    glyph_bits = 15'b101_101_111_001_001;
            4'd5:    glyph_bits = 15'b111_100_111_001_111;
            4'd6:    glyph_bits = 15'b111_100_111_101_111;
            4'd7:    glyph_bits = 15'b111_001_001_001_001;
            4'd8:    glyph_bits = 15'b111_101_111_101_111;
            4'd9:    glyph_bits = 15'b111_101_111_001_111;
            default: glyph_bits = 15'b0;
        endcase
    endfunction

    // Inclusive span test in 9 bits so base+len never wraps.
    function automatic logic in_span(input logic [8:0] pos, input logic [8:0] base,
                                     input logic [8:0] len);
        in_span = (pos >= base) && (pos <= base + len - 9'd1);
    endfunction

endpackage

// File: rtl/pong_renderer_digit_glyph_rom.sv
// 3x5 digit font lookup; blank for non-decimal digits or out-of-glyph cells.
module digit_glyph_rom
    import pong_renderer_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic [2:0] i_row,
    input  logic [1:0] i_col,
    output logic       o_pixel_c
);

    logic [14:0] w_bits;

    always_comb begin
        o_pixel_c = 1'b0;
        w_bits    = glyph_bits(i_digit) << (4'(i_row) * 4'd3 + 4'(i_col));
        if (i_row < 3'(GLYPH_ROWS) && i_col < 2'(GLYPH_COLS)) begin
            o_pixel_c = w_bits[14];
        end
    end

endmodule

// File: rtl/pong_renderer.sv
// 640x480 VGA renderer for Pong: frame-latched game state, hit decode, 2-stage colour pipe.
module pong_renderer
    import pong_renderer_pkg::*;
#(
    parameter int unsigned BLOCK       = 4,
    parameter int unsigned PLAYER_SIZE = 32,
    parameter int unsigned SCALE_LOG2  = 2
) (
    input  logic       PIXEL_CLK,
    input  logic       reset,
    input  logic [7:0] ballX_in,
    input  logic [6:0] ballY_in,
    input  logic [7:0] playerXPos_in,
    input  logic [6:0] playerYPos_in,
    input  logic [7:0] comXPos_in,
    input  logic [6:0] comYPos_in,
    input  logic [3:0] playerScore_in,
    input  logic [3:0] comScore_in,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [7:0] RGB,
    output logic       GAME_TICK
);

    logic [CNT_W-1:0] r_hcount, r_vcount, w_hcount_nxt, w_vcount_nxt;
    logic             r_game_tick;
    shadow_t          r_shadow, w_shadow_in;
    logic [7:0]       w_gx, w_gy, w_p_dx, w_c_dx, w_dy;
    logic             w_ball, w_player, w_com, w_net, w_score, w_visible;
    logic             w_p_area, w_c_area, w_p_pix, w_c_pix;
    logic             r_s1_ball, r_s1_player, r_s1_com, r_s1_score, r_s1_net;
    logic             r_s1_visible, r_s1_over, r_s1_hsync, r_s1_vsync;
    logic [7:0]       r_rgb, w_rgb_nxt;
    logic             r_hsync, r_vsync;

    always_comb begin
        w_hcount_nxt = r_hcount + CNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (r_hcount == CNT_W'(H_TOTAL - 1)) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = (r_vcount == CNT_W'(V_TOTAL - 1)) ? '0 : r_vcount + CNT_W'(1);
        end
    end

    assign w_shadow_in = '{ball_x: ballX_in, ball_y: ballY_in,
                           player_x: playerXPos_in, player_y: playerYPos_in,
                           com_x: comXPos_in, com_y: comYPos_in,
                           player_score: playerScore_in, com_score: comScore_in};

    // Tick is registered one cycle early so it is high exactly while the count is (0, 480).
    always_ff @(posedge PIXEL_CLK or negedge reset) begin
        if (!reset) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_game_tick <= 1'b0;
            r_shadow    <= '0;
        end else begin
            r_hcount    <= w_hcount_nxt;
            r_vcount    <= w_vcount_nxt;
            r_game_tick <= (w_hcount_nxt == '0) && (w_vcount_nxt == CNT_W'(V_VISIBLE));
            if (r_game_tick) begin
                r_shadow <= w_shadow_in;
            end
        end
    end

    assign w_gx      = 8'(r_hcount >> SCALE_LOG2);
    assign w_gy      = 8'(r_vcount >> SCALE_LOG2);
    assign w_visible = (r_hcount < CNT_W'(H_VISIBLE)) && (r_vcount < CNT_W'(V_VISIBLE));

    assign w_ball   = in_span(9'(w_gx), 9'(r_shadow.ball_x), 9'(BLOCK))
                   && in_span(9'(w_gy), 9'(r_shadow.ball_y), 9'(BLOCK));
    assign w_player = in_span(9'(w_gx), 9'(r_shadow.player_x), 9'(BLOCK))
                   && in_span(9'(w_gy), 9'(r_shadow.player_y), 9'(PLAYER_SIZE));
    assign w_com    = in_span(9'(w_gx), 9'(r_shadow.com_x), 9'(BLOCK))
                   && in_span(9'(w_gy), 9'(r_shadow.com_y), 9'(PLAYER_SIZE));
    assign w_net    = (w_gx == 8'(NET_X)) && !w_gy[2];

    // Digit boxes are 6x10 logical px; offsets inside them pick the 2x2 glyph cell.
    assign w_p_dx   = w_gx - 8'(P_DIGIT_X);
    assign w_c_dx   = w_gx - 8'(C_DIGIT_X);
    assign w_dy     = w_gy - 8'(DIGIT_Y);
    assign w_p_area = in_span(9'(w_gx), 9'(P_DIGIT_X), 9'(DIGIT_W))
                   && in_span(9'(w_gy), 9'(DIGIT_Y), 9'(DIGIT_H));
    assign w_c_area = in_span(9'(w_gx), 9'(C_DIGIT_X), 9'(DIGIT_W))
                   && in_span(9'(w_gy), 9'(DIGIT_Y), 9'(DIGIT_H));

    digit_glyph_rom u_player_digit (
        .i_digit   (r_shadow.player_score),
        .i_row     (3'(w_dy >> GLYPH_CELL_LOG2)),
        .i_col     (2'(w_p_dx >> GLYPH_CELL_LOG2)),
        .o_pixel_c (w_p_pix)
    );

    digit_glyph_rom u_com_digit (
        .i_digit   (r_shadow.com_score),
        .i_row     (3'(w_dy >> GLYPH_CELL_LOG2)),
        .i_col     (2'(w_c_dx >> GLYPH_CELL_LOG2)),
        .o_pixel_c (w_c_pix)
    );

    assign w_score = (w_p_area && w_p_pix) || (w_c_area && w_c_pix);

    always_ff @(posedge PIXEL_CLK or negedge reset) begin
        if (!reset) begin
            r_s1_ball    <= 1'b0;
            r_s1_player  <= 1'b0;
            r_s1_com     <= 1'b0;
            r_s1_score   <= 1'b0;
            r_s1_net     <= 1'b0;
            r_s1_visible <= 1'b0;
            r_s1_over    <= 1'b0;
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
        end else begin
            r_s1_ball    <= w_ball;
            r_s1_player  <= w_player;
            r_s1_com     <= w_com;
            r_s1_score   <= w_score;
            r_s1_net     <= w_net;
            r_s1_visible <= w_visible;
            r_s1_over    <= (r_shadow.player_score == 4'(GAME_OVER_SCORE))
                         || (r_shadow.com_score == 4'(GAME_OVER_SCORE));
            r_s1_hsync   <= !((r_hcount >= CNT_W'(H_SYNC_START)) && (r_hcount < CNT_W'(H_SYNC_END)));
            r_s1_vsync   <= !((r_vcount >= CNT_W'(V_SYNC_START)) && (r_vcount < CNT_W'(V_SYNC_END)));
        end
    end

    always_comb begin
        w_rgb_nxt = COL_BLANK;
        if (r_s1_visible) begin
            if (r_s1_ball)        w_rgb_nxt = COL_BALL;
            else if (r_s1_player) w_rgb_nxt = COL_PLAYER;
            else if (r_s1_com)    w_rgb_nxt = COL_COM;
            else if (r_s1_score)  w_rgb_nxt = COL_SCORE;
            else if (r_s1_net)    w_rgb_nxt = COL_NET;
            else                  w_rgb_nxt = r_s1_over ? COL_BG_OVER : COL_BG;
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge reset) begin
        if (!reset) begin
            r_rgb   <= COL_BLANK;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb_nxt;
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
        end
    end

    assign RGB       = r_rgb;
    assign HSYNC     = r_hsync;
    assign VSYNC     = r_vsync;
    assign GAME_TICK = r_game_tick;

endmodule

// File: tb/tb_pong_renderer.sv
// Bench for pong_renderer: sync timing, frame tick, mid-frame reset and pixel colour vectors.
module tb_pong_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ballX_in, playerXPos_in, comXPos_in;
    logic [6:0] ballY_in, playerYPos_in, comYPos_in;
    logic [3:0] playerScore_in, comScore_in;
    logic       HSYNC, VSYNC, GAME_TICK;
    logic [7:0] RGB;

    always #20 clk = ~clk;

    pong_renderer dut (
        .PIXEL_CLK      (clk),
        .reset          (rst_n),
        .ballX_in       (ballX_in),
        .ballY_in       (ballY_in),
        .playerXPos_in  (playerXPos_in),
        .playerYPos_in  (playerYPos_in),
        .comXPos_in     (comXPos_in),
        .comYPos_in     (comYPos_in),
        .playerScore_in (playerScore_in),
        .comScore_in    (comScore_in),
        .HSYNC          (HSYNC),
        .VSYNC          (VSYNC),
        .RGB            (RGB),
        .GAME_TICK      (GAME_TICK)
    );

    // Reference raster position: what the DUT counters hold during the current cycle.
    int m_h, m_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h <= 0;
            m_v <= 0;
        end else if (m_h == 799) begin
            m_h <= 0;
            m_v <= (m_v == 524) ? 0 : m_v + 1;
        end else begin
            m_h <= m_h + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int         ph;
        int         h;
        int         v;
        logic [7:0] rgb;
    } vec_t;

    typedef struct {
        int         idx;
        longint     due;
        logic [7:0] exp;
    } sb_t;

    localparam int NV = 43;
    vec_t   vt[NV];
    sb_t    sbq[$];
    sb_t    e;
    bit     armed    = 1'b0;
    int     ph       = 0;
    longint cyc      = 0;
    int     pushed   = 0;
    int     tick_err = 0;

    // Expected pixel queued when the raster reaches it; compared two cycles later.
    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            if (m_h == 0 && m_v == 480) ph++;
            if (GAME_TICK !== (m_h == 0 && m_v == 480)) tick_err++;
            while (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                check($sformatf("px%0d(h%0d,v%0d)", e.idx, vt[e.idx].h, vt[e.idx].v), RGB, e.exp);
            end
            for (int i = 0; i < NV; i++) begin
                if (vt[i].ph == ph && vt[i].h == m_h && vt[i].v == m_v) begin
                    sbq.push_back('{i, cyc + 2, vt[i].rgb});
                    pushed++;
                end
            end
        end
    end

    int n, w, p, bad;
    bit changed;

    initial begin
        // Frame 0 after the final release: every shadow is zero, scores show "0".
        vt[0]  = '{0,   0,   0, 8'hFF};  vt[1]  = '{0,  12,  12, 8'hFF};
        vt[2]  = '{0,  16,   0, 8'h00};  vt[3]  = '{0,   0,  16, 8'h1C};
        vt[4]  = '{0,  12, 124, 8'h1C};  vt[5]  = '{0,   0, 128, 8'h00};
        vt[6]  = '{0, 316,   0, 8'h92};  vt[7]  = '{0, 316,  16, 8'h00};
        vt[8]  = '{0, 316,  32, 8'h92};  vt[9]  = '{0, 256,  16, 8'hFF};
        vt[10] = '{0, 264,  24, 8'h00};  vt[11] = '{0, 360,  16, 8'hFF};
        vt[12] = '{0,   0, 120, 8'h1C};  vt[13] = '{0,  12, 160, 8'h00};
        vt[14] = '{0, 368,  32, 8'h00};  vt[15] = '{0, 368,  48, 8'hFF};
        vt[16] = '{0, 360,  56, 8'h00};
        // Frame 1: ball(100,50), player(3,40), com(156,0), scores 9 / 12.
        vt[17] = '{1, 400, 200, 8'hFF};  vt[18] = '{1, 415, 215, 8'hFF};
        vt[19] = '{1, 399, 200, 8'h02};  vt[20] = '{1, 416, 200, 8'h02};
        vt[21] = '{1, 400, 199, 8'h02};  vt[22] = '{1, 400, 216, 8'h02};
        vt[23] = '{1,  12, 160, 8'h1C};  vt[24] = '{1,  27, 287, 8'h1C};
        vt[25] = '{1,  12, 159, 8'h02};  vt[26] = '{1,  28, 200, 8'h02};
        vt[27] = '{1,  11, 200, 8'h02};  vt[28] = '{1,  12, 288, 8'h02};
        vt[29] = '{1, 624,   0, 8'hE0};  vt[30] = '{1, 639, 127, 8'hE0};
        vt[31] = '{1, 623,   0, 8'h02};  vt[32] = '{1, 624, 128, 8'h02};
        vt[33] = '{1, 316,   0, 8'h92};  vt[34] = '{1, 316, 480, 8'h00};
        vt[35] = '{1, 700, 100, 8'h00};  vt[36] = '{1, 256,  16, 8'hFF};
        vt[37] = '{1, 256,  40, 8'h02};  vt[38] = '{1, 272,  40, 8'hFF};
        vt[39] = '{1, 264,  24, 8'h02};  vt[40] = '{1, 264,  32, 8'hFF};
        vt[41] = '{1, 360,  16, 8'h02};  vt[42] = '{1, 368,  48, 8'h02};

        {ballX_in, ballY_in, playerXPos_in, playerYPos_in} = '0;
        {comXPos_in, comYPos_in, playerScore_in, comScore_in} = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_hsync", HSYNC, 1);
        check("rst_vsync", VSYNC, 1);
        check("rst_rgb", RGB, 0);
        check("rst_tick", GAME_TICK, 0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (HSYNC === 1'b0) break;
            n++;
        end
        check("hsync_first_low", n, 658);
        w = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            w++;
            if (HSYNC === 1'b1) break;
        end
        check("hsync_low_width", w, 96);
        p = w;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            p++;
            if (HSYNC === 1'b0) break;
        end
        check("hsync_period", p, 800);

        // Abort the frame on a net pixel of line 300.
        for (int k = 0; k < 400000; k++) begin
            @(negedge clk);
            if (m_v == 300 && m_h == 319) break;
        end
        check("net_line300_pre_reset", RGB, 8'h92);
        #5 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", RGB, 0);
        check("async_rst_hsync", HSYNC, 1);
        check("async_rst_vsync", VSYNC, 1);
        check("async_rst_tick", GAME_TICK, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (HSYNC !== 1'b1 || VSYNC !== 1'b1 || RGB !== 8'h00 || GAME_TICK !== 1'b0) bad++;
        end
        check("reset_hold_cycles_bad", bad, 0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        armed = 1'b1;
        n = 0;
        changed = 1'b0;
        for (int k = 0; k < 400000; k++) begin
            @(negedge clk);
            if (GAME_TICK === 1'b1) break;
            n++;
            if (!changed && m_v == 100) begin
                ballX_in = 8'd100;      ballY_in = 7'd50;
                playerXPos_in = 8'd3;   playerYPos_in = 7'd40;
                comXPos_in = 8'd156;    comYPos_in = 7'd0;
                playerScore_in = 4'd9;  comScore_in = 4'd12;
                changed = 1'b1;
            end
        end
        check("first_tick_after_release", n, 384000);

        n = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            n++;
            if (VSYNC === 1'b0) break;
        end
        check("vsync_after_tick", n, 8002);
        w = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            w++;
            if (VSYNC === 1'b1) break;
        end
        check("vsync_low_width", w, 1600);
        p = w;
        for (int k = 0; k < 430000; k++) begin
            @(negedge clk);
            p++;
            if (VSYNC === 1'b0) break;
        end
        check("vsync_period", p, 420000);

        repeat (4) @(negedge clk);
        check("pixel_vectors_seen", pushed, NV);
        check("scoreboard_drained", sbq.size(), 0);
        check("tick_pulse_errors", tick_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
